// File: rtl/instr_fetch.sv
// Instruction fetch unit: single outstanding request to instruction memory,
// one-entry output holding register toward decode, redirect/squash handling.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nreset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_word,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [7:0]  fetch_count
);

    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] target;
    logic        squash;
    logic [31:0] redir_addr;

    assign redir_addr = {redirect_pc[31:2], 2'b00};

    // imem_addr doubles as the request address register; it only moves
    // when no request is outstanding or on the acking edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            pc          <= START_PC;
            target      <= START_PC;
            squash      <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= START_PC;
            inst_valid  <= 1'b0;
            inst_word   <= '0;
            inst_pc     <= '0;
            fetch_count <= '0;
        end else begin
            if (inst_valid && inst_ready)
                fetch_count <= fetch_count + 8'd1;

            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    if (redirect) begin
                        pc        <= redir_addr;
                        imem_addr <= redir_addr;
                    end else begin
                        imem_addr <= pc;
                    end
                end

                FETCH: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            pc        <= redir_addr;
                            imem_addr <= redir_addr;
                            squash    <= 1'b0;
                        end else if (squash) begin
                            pc        <= target;
                            imem_addr <= target;
                            squash    <= 1'b0;
                        end else begin
                            inst_word  <= imem_rdata;
                            inst_pc    <= imem_addr;
                            pc         <= imem_addr + 32'd4;
                            inst_valid <= 1'b1;
                            imem_req   <= 1'b0;
                            state      <= HOLD;
                        end
                    end else if (redirect) begin
                        // request is in flight: let it finish, then discard it
                        squash <= 1'b1;
                        target <= redir_addr;
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        pc         <= redir_addr;
                        imem_addr  <= redir_addr;
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        state      <= FETCH;
                    end else if (inst_ready) begin
                        imem_addr  <= pc;
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        state      <= FETCH;
                    end
                end

                default: begin
                    state      <= IDLE;
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: per-cycle vector table, delivery scoreboard,
// and directed sequences for squash, async reset and address/count wrap.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        nreset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_word;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [7:0]  fetch_count;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .nreset(nreset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_word(inst_word), .inst_pc(inst_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_count(fetch_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } sb_t;

    typedef struct {
        logic        ack, ready, redir;
        logic [31:0] rpc;
        logic        push;
        logic [31:0] push_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [7:0]  exp_cnt;
    } vec_t;

    localparam logic [31:0] WORD = 32'hE084_3003;

    sb_t  sbq[$];
    vec_t tbl[18];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Pop/compare on the handshake (sampled at negedge), then advance one edge.
    task automatic step();
        sb_t e;
        @(negedge clk);
        if (inst_valid && inst_ready) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: delivery pc %h with nothing expected", inst_pc);
            end else begin
                e = sbq.pop_front();
                chk("sb_pc", inst_pc, e.pc);
                chk("sb_word", inst_word, e.word);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] word);
        sb_t e;
        e.pc = pc;
        e.word = word;
        sbq.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"},   32'(imem_req), 32'd0);
        chk({tag, "_addr"},  imem_addr, 32'h0);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_word"},  inst_word, 32'h0);
        chk({tag, "_pc"},    inst_pc, 32'h0);
        chk({tag, "_cnt"},   32'(fetch_count), 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 nreset = 1'b1;
    endtask

    task automatic setv(input int i, input logic ack, input logic ready, input logic redir,
                        input logic [31:0] rpc, input logic psh, input logic [31:0] ppc,
                        input logic req, input logic [31:0] addr, input logic valid,
                        input logic [31:0] ipc, input logic [7:0] cnt);
        tbl[i].ack = ack;       tbl[i].ready = ready;   tbl[i].redir = redir;
        tbl[i].rpc = rpc;       tbl[i].push = psh;      tbl[i].push_pc = ppc;
        tbl[i].exp_req = req;   tbl[i].exp_addr = addr; tbl[i].exp_valid = valid;
        tbl[i].exp_pc = ipc;    tbl[i].exp_cnt = cnt;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] w;

        //   i  ack rdy rdr rpc        psh ppc        req addr       vld ipc        cnt
        setv( 0, 1, 1, 0, 32'h0,     0, 32'h0,    1, 32'h000,   0, 32'h000,   8'd0);
        setv( 1, 1, 1, 0, 32'h0,     0, 32'h0,    0, 32'h000,   1, 32'h000,   8'd0);
        setv( 2, 1, 1, 0, 32'h0,     1, 32'h000,  1, 32'h004,   0, 32'h000,   8'd1);
        setv( 3, 1, 1, 0, 32'h0,     0, 32'h0,    0, 32'h004,   1, 32'h004,   8'd1);
        setv( 4, 1, 1, 0, 32'h0,     1, 32'h004,  1, 32'h008,   0, 32'h004,   8'd2);
        setv( 5, 1, 0, 0, 32'h0,     0, 32'h0,    0, 32'h008,   1, 32'h008,   8'd2);
        for (int i = 6; i <= 10; i++)
            setv(i, 1, 0, 0, 32'h0,  0, 32'h0,    0, 32'h008,   1, 32'h008,   8'd2);
        setv(11, 1, 1, 0, 32'h0,     1, 32'h008,  1, 32'h00C,   0, 32'h008,   8'd3);
        setv(12, 1, 0, 0, 32'h0,     0, 32'h0,    0, 32'h00C,   1, 32'h00C,   8'd3);
        setv(13, 1, 0, 1, 32'h203,   0, 32'h0,    1, 32'h200,   0, 32'h00C,   8'd3);
        setv(14, 1, 1, 0, 32'h0,     0, 32'h0,    0, 32'h200,   1, 32'h200,   8'd3);
        setv(15, 1, 1, 0, 32'h0,     1, 32'h200,  1, 32'h204,   0, 32'h200,   8'd4);
        setv(16, 1, 1, 0, 32'h0,     0, 32'h0,    0, 32'h204,   1, 32'h204,   8'd4);
        setv(17, 1, 1, 1, 32'h300,   1, 32'h204,  1, 32'h300,   0, 32'h204,   8'd5);

        nreset = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = WORD;
        inst_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        #3;
        check_reset_vals("rst0");
        release_reset();

        // Streaming, decode stall, redirect in HOLD with and without ready
        foreach (tbl[i]) begin
            imem_ack    = tbl[i].ack;
            inst_ready  = tbl[i].ready;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            if (tbl[i].push) push(tbl[i].push_pc, WORD);
            step();
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].exp_addr);
            chk($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk($sformatf("v%0d_pc", i), inst_pc, tbl[i].exp_pc);
                chk($sformatf("v%0d_word", i), inst_word, WORD);
            end
            chk($sformatf("v%0d_cnt", i), 32'(fetch_count), 32'(tbl[i].exp_cnt));
        end

        // Asynchronous reset while a request is outstanding
        imem_ack = 1'b0;
        inst_ready = 1'b0;
        redirect = 1'b0;
        step();
        chk("wait_req", 32'(imem_req), 32'd1);
        chk("wait_addr", imem_addr, 32'h300);
        #2 nreset = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        release_reset();
        step();
        chk("rel_req", 32'(imem_req), 32'd1);
        chk("rel_addr", imem_addr, 32'h0);

        // Late ack with redirect mid-wait: old data squashed, refetch at 0x100
        step();
        chk("sq_addr1", imem_addr, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        step();
        chk("sq_addr2", imem_addr, 32'h0);
        redirect = 1'b0;
        step();
        chk("sq_addr3", imem_addr, 32'h0);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        chk("sq_req", 32'(imem_req), 32'd1);
        chk("sq_addr", imem_addr, 32'h100);
        chk("sq_valid", 32'(inst_valid), 32'd0);
        imem_rdata = 32'h1234_5678;
        step();
        chk("sq_vld2", 32'(inst_valid), 32'd1);
        chk("sq_pc", inst_pc, 32'h100);
        chk("sq_word", inst_word, 32'h1234_5678);
        inst_ready = 1'b1;
        push(32'h100, 32'h1234_5678);
        step();
        chk("sq_cnt", 32'(fetch_count), 32'd1);

        // 256 deliveries from a redirect in IDLE: PC and counter both wrap
        nreset = 1'b0;
        #1;
        release_reset();
        inst_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF1;
        step();
        redirect = 1'b0;
        chk("wr_addr0", imem_addr, 32'hFFFF_FFF0);
        exp_pc = 32'hFFFF_FFF0;
        for (int k = 0; k < 256; k++) begin
            w = 32'hA500_0000 | 32'(k);
            imem_rdata = w;
            inst_ready = 1'b0;
            step();
            chk($sformatf("wr%0d_pc", k), inst_pc, exp_pc);
            inst_ready = 1'b1;
            push(exp_pc, w);
            step();
            exp_pc = exp_pc + 32'd4;
            chk($sformatf("wr%0d_addr", k), imem_addr, exp_pc);
            if (k == 254) chk("wr_cnt255", 32'(fetch_count), 32'd255);
        end
        chk("wr_cnt0", 32'(fetch_count), 32'd0);
        chk("sb_left", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
